branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Responder to the fetch stage's next-PC lookup. Fetch presents its current PC; this block answers in the same cycle with hit and predicted target, which fetch uses to steer its next PC.
- Updated from execute with the resolved branch/jump outcome.
- Prediction granularity is halfword, because compressed instructions are supported.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of table entries; must be a power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width (derived).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- pc_i  input  XLEN  fetch lookup PC (fetch's current pc register).
- hit_o  output  1  predict taken for pc_i (combinational).
- target_o  output  XLEN  predicted target for pc_i (combinational).
- upd_valid_i  input  1  resolved control-flow instruction in execute this cycle.
- upd_pc_i  input  XLEN  PC of the resolved instruction.
- upd_target_i  input  XLEN  resolved target address.
- upd_taken_i  input  1  resolved direction.
- upd_jump_i  input  1  instruction is an unconditional jump (jal/jalr).
- flush_all_i  input  1  invalidate entire table (fence.i / context change).

Behaviour:
- Indexing and tags:
  - idx = pc[IDX_W:1].
  - tag = pc[XLEN-1:IDX_W+1]; bit 0 is ignored.
  - Each entry holds: valid, tag, target[XLEN-1:0], ctr[1:0].
- Lookup (combinational from registered state, zero latency):
  - hit_o = valid[idx] & (tag[idx]==tag(pc_i)) & ctr[idx][1].
  - target_o = target[idx] whenever valid and tag match, else 0.
  - hit_o must never be X: an invalid entry forces 0.
- Update (registered, takes effect on the next rising edge when upd_valid_i=1):
  - Tag match, taken: ctr saturating increment (max 2'b11); target <= upd_target_i.
  - Tag match, not taken: ctr saturating decrement (min 2'b00); target unchanged; entry stays valid.
  - Tag match, upd_jump_i=1: ctr <= 2'b11; target <= upd_target_i, regardless of upd_taken_i.
  - Miss (invalid or tag differs), taken or jump: allocate. valid<=1, tag<=tag(upd_pc_i), target<=upd_target_i, ctr<=2'b11 for jump, 2'b10 otherwise. Replaces any previous occupant.
  - Miss, not taken, not jump: no state change (no allocation on not-taken).
- Simultaneous lookup and update to the same index in one cycle: lookup returns pre-update state. The new state is visible from the next cycle. No write-through bypass.
- flush_all_i:
  - Clears all valid bits at the next edge. Tags, targets and counters need not be cleared.
  - If upd_valid_i is asserted in the same cycle, flush wins: the table is empty afterwards.
- Reset (asynchronous, any time, including mid-update):
  - All valid<=0, all ctr<=2'b01, targets/tags<=0.
  - hit_o=0 and target_o=0 for any pc_i while reset is held and after release until the first allocation.
- Counter arithmetic is 2-bit saturating only; no wrap from 11 to 00 or from 00 to 11.
- Aliasing:
  - Two PCs sharing idx but differing in tag evict each other.
  - Two PCs differing only in bit 0 map to the same entry.
- No stalls or backpressure: update is accepted every cycle it is presented.

Test Plan:
- Reset, then pc_i=0x8000_0000 -> hit_o=0, target_o=0. Release reset, same pc -> still 0.
- Update pc=0x8000_0010, taken, target=0x8000_0100 -> next cycle lookup of 0x8000_0010 gives hit_o=1, target_o=0x8000_0100 (ctr=10). Two not-taken updates -> ctr 00, hit_o=0, target_o still 0x8000_0100.
- Jump at 0x8000_0004, target 0x8000_0200, upd_taken_i=0, upd_jump_i=1 -> hit_o=1 (ctr=11). Three taken updates -> ctr stays 11, no wrap.
- Alias (ENTRIES=16): allocate 0x8000_0008, then taken update for 0x8000_0028 (same idx 4, different tag) -> lookup 0x8000_0008 hit_o=0; lookup 0x8000_0028 hit_o=1.
- Same-cycle lookup and allocate of 0x8000_0030 -> hit_o=0 that cycle, hit_o=1 the next cycle.
- flush_all_i together with upd_valid_i (taken) -> all lookups miss afterwards. Assert rst_i asynchronously mid-cycle -> hit_o drops to 0 before the next clock edge.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and execute-update bus of the branch target buffer.
// The master drives the PCs and updates; the slave answers lookups combinationally.
interface branch_target_buffer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_i;
    logic            hit_o;
    logic [XLEN-1:0] target_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_taken_i;
    logic            upd_jump_i;
    logic            flush_all_i;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, upd_jump_i, flush_all_i,
        input  hit_o, target_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, upd_jump_i, flush_all_i,
        output hit_o, target_o
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped halfword-granular BTB with 2-bit counters; lookup is combinational (zero latency).
// Updates and flushes commit on the next edge; no backpressure, an update is accepted every cycle.
module branch_target_buffer #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    branch_target_buffer_if.slave   bus
);
    localparam int TAG_W = XLEN - IDX_W - 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t entry_q [ENTRIES];
    entry_t entry_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_match;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;
    logic             upd_we;

    // Bit 0 never participates: both halves of a halfword share one entry.
    assign lk_idx  = bus.pc_i[IDX_W:1];
    assign lk_tag  = bus.pc_i[XLEN-1:IDX_W+1];
    assign upd_idx = bus.upd_pc_i[IDX_W:1];
    assign upd_tag = bus.upd_pc_i[XLEN-1:IDX_W+1];

    assign lk_match     = entry_q[lk_idx].valid && (entry_q[lk_idx].tag == lk_tag);
    assign bus.hit_o    = lk_match && entry_q[lk_idx].ctr[1];
    assign bus.target_o = lk_match ? entry_q[lk_idx].target : '0;

    assign upd_match = entry_q[upd_idx].valid && (entry_q[upd_idx].tag == upd_tag);

    always_comb begin
        entry_d = entry_q[upd_idx];
        upd_we  = 1'b0;
        if (bus.upd_valid_i) begin
            if (upd_match) begin
                upd_we = 1'b1;
                if (bus.upd_jump_i) begin
                    entry_d.ctr    = 2'b11;
                    entry_d.target = bus.upd_target_i;
                end else if (bus.upd_taken_i) begin
                    entry_d.ctr    = (entry_q[upd_idx].ctr == 2'b11) ? 2'b11 : entry_q[upd_idx].ctr + 2'b01;
                    entry_d.target = bus.upd_target_i;
                end else begin
                    entry_d.ctr    = (entry_q[upd_idx].ctr == 2'b00) ? 2'b00 : entry_q[upd_idx].ctr - 2'b01;
                end
            end else if (bus.upd_taken_i || bus.upd_jump_i) begin
                // Not-taken misses never allocate, so a cold branch cannot evict a useful entry.
                upd_we         = 1'b1;
                entry_d.valid  = 1'b1;
                entry_d.tag    = upd_tag;
                entry_d.target = bus.upd_target_i;
                entry_d.ctr    = bus.upd_jump_i ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
        end else if (bus.flush_all_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else if (upd_we) begin
            entry_q[upd_idx] <= entry_d;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed vector table plus randomized traffic against a behavioural BTB model.
module tb_branch_target_buffer;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_target_buffer_if #(.XLEN(XLEN)) bif ();

    branch_target_buffer #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif.slave)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        bit          uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        bit          tk;
        bit          jp;
        bit          fl;
        bit          eh;
        logic [31:0] et;
    } vec_t;

    vec_t tbl[$];

    // Reference model: one record per set, counters kept as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic vec_t mk(string n, logic [31:0] pc, bit uv, logic [31:0] upc,
                                logic [31:0] utgt, bit tk, bit jp, bit fl, bit eh, logic [31:0] et);
        vec_t v;
        v.name = n; v.pc = pc; v.uv = uv; v.upc = upc; v.utgt = utgt;
        v.tk = tk; v.jp = jp; v.fl = fl; v.eh = eh; v.et = et;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit h, output logic [31:0] t);
        int i;
        i = int'((pc >> 1) % ENTRIES);
        h = 1'b0;
        t = '0;
        if (m_valid[i] && m_tag[i] == (pc >> (IDX_W + 1))) begin
            t = m_tgt[i];
            h = (m_ctr[i] >= 2);
        end
    endtask

    task automatic model_update();
        int i;
        logic [31:0] t;
        i = int'((bif.upd_pc_i >> 1) % ENTRIES);
        t = bif.upd_pc_i >> (IDX_W + 1);
        if (bif.flush_all_i) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (bif.upd_valid_i) begin
            if (m_valid[i] && m_tag[i] == t) begin
                if (bif.upd_jump_i) begin
                    m_ctr[i] = 3; m_tgt[i] = bif.upd_target_i;
                end else if (bif.upd_taken_i) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = bif.upd_target_i;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (bif.upd_taken_i || bif.upd_jump_i) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_tgt[i]   = bif.upd_target_i;
                m_ctr[i]   = bif.upd_jump_i ? 3 : 2;
            end
        end
    endtask

    task automatic drive(vec_t v);
        bif.pc_i         = v.pc;
        bif.upd_valid_i  = v.uv;
        bif.upd_pc_i     = v.upc;
        bif.upd_target_i = v.utgt;
        bif.upd_taken_i  = v.tk;
        bif.upd_jump_i   = v.jp;
        bif.flush_all_i  = v.fl;
    endtask

    // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        bit          mh;
        logic [31:0] mt;
        vec_t        v;

        model_reset();
        drive(mk("idle", 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0));

        #3;
        check("reset_held_hit", {31'b0, bif.hit_o}, 32'd0);
        check("reset_held_tgt", bif.target_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rel_hit", {31'b0, bif.hit_o}, 32'd0);
        check("reset_rel_tgt", bif.target_o, 32'd0);
        @(posedge clk);
        #1;

        tbl.push_back(mk("alloc_same_cycle", 32'h8000_0010, 1, 32'h8000_0010, 32'h8000_0100, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk("ctr10_hit",        32'h8000_0010, 1, 32'h8000_0010, 32'h0,        0, 0, 0, 1, 32'h8000_0100));
        tbl.push_back(mk("ctr01_miss",       32'h8000_0010, 1, 32'h8000_0010, 32'h0,        0, 0, 0, 0, 32'h8000_0100));
        tbl.push_back(mk("ctr00_sat",        32'h8000_0010, 1, 32'h8000_0010, 32'h0,        0, 0, 0, 0, 32'h8000_0100));
        tbl.push_back(mk("ctr00_then_tk",    32'h8000_0010, 1, 32'h8000_0010, 32'h8000_0180, 1, 0, 0, 0, 32'h8000_0100));
        tbl.push_back(mk("ctr01_newtgt",     32'h8000_0010, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h8000_0180));
        tbl.push_back(mk("jump_alloc",       32'h8000_0004, 1, 32'h8000_0004, 32'h8000_0200, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk("jump_ctr11_a",     32'h8000_0004, 1, 32'h8000_0004, 32'h8000_0200, 1, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("jump_ctr11_b",     32'h8000_0004, 1, 32'h8000_0004, 32'h8000_0200, 1, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("jump_ctr11_c",     32'h8000_0004, 1, 32'h8000_0004, 32'h8000_0200, 1, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("no_wrap_11",       32'h8000_0004, 1, 32'h8000_0004, 32'h0,        0, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("bit0_alias",       32'h8000_0005, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("alias_alloc_a",    32'h8000_0008, 1, 32'h8000_0008, 32'h8000_0300, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk("alias_evict",      32'h8000_0008, 1, 32'h8000_0028, 32'h8000_0400, 1, 0, 0, 1, 32'h8000_0300));
        tbl.push_back(mk("alias_old_miss",   32'h8000_0008, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("alias_new_hit",    32'h8000_0028, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h8000_0400));
        tbl.push_back(mk("same_cycle_30",    32'h8000_0030, 1, 32'h8000_0030, 32'h8000_0500, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk("next_cycle_30",    32'h8000_0030, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h8000_0500));
        tbl.push_back(mk("evicted_10",       32'h8000_0010, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("nt_miss_noalloc",  32'h8000_0004, 1, 32'h8000_0024, 32'h8000_0700, 0, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("nt_miss_kept",     32'h8000_0004, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h8000_0200));
        tbl.push_back(mk("nt_miss_absent",   32'h8000_0024, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("flush_with_upd",   32'h8000_0030, 1, 32'h8000_0040, 32'h8000_0600, 1, 0, 1, 1, 32'h8000_0500));
        tbl.push_back(mk("flushed_30",       32'h8000_0030, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("flushed_40",       32'h8000_0040, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0));
        tbl.push_back(mk("flushed_04",       32'h8000_0004, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0));

        foreach (tbl[n]) begin
            drive(tbl[n]);
            @(negedge clk);
            check({tbl[n].name, "_hit"}, {31'b0, bif.hit_o}, {31'b0, tbl[n].eh});
            check({tbl[n].name, "_tgt"}, bif.target_o, tbl[n].et);
            finish_cycle();
        end

        for (int c = 0; c < 600; c++) begin
            v.name = "rand";
            v.pc   = 32'h8000_0000 | 32'($urandom_range(0, 127));
            v.uv   = ($urandom_range(0, 3) != 0);
            v.upc  = 32'h8000_0000 | 32'($urandom_range(0, 127));
            v.utgt = $urandom & 32'hFFFF_FFFE;
            v.tk   = $urandom_range(0, 1) == 1;
            v.jp   = ($urandom_range(0, 5) == 0);
            v.fl   = ($urandom_range(0, 60) == 0);
            drive(v);
            @(negedge clk);
            model_lookup(v.pc, mh, mt);
            check("rand_hit", {31'b0, bif.hit_o}, {31'b0, mh});
            check("rand_tgt", bif.target_o, mt);
            finish_cycle();
        end

        drive(mk("pre_rst_alloc", 32'h8000_0070, 1, 32'h8000_0070, 32'h8000_0800, 0, 1, 0, 0, 0));
        finish_cycle();
        drive(mk("pre_rst_look", 32'h8000_0070, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("pre_rst_hit", {31'b0, bif.hit_o}, 32'd1);
        check("pre_rst_tgt", bif.target_o, 32'h8000_0800);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hit", {31'b0, bif.hit_o}, 32'd0);
        check("async_rst_tgt", bif.target_o, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_hit", {31'b0, bif.hit_o}, 32'd0);
        check("post_rst_tgt", bif.target_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
